// File: rtl/dma_subsystem_if.sv
// Bus bundle for the DMA subsystem: CPU port, IO port and the shared RAM port.
// slave = DMA engine side, master = surrounding system (CPU, IO device, RAM).
interface dma_subsystem_if #(
  parameter int SZ  = 8,
  parameter int WSZ = 8
);
  logic [SZ-1:0]  ram_addr;
  logic [WSZ-1:0] ram_wdata;
  logic [WSZ-1:0] ram_rdata;
  logic           ram_w_notr;

  logic           cpu_req;
  logic [SZ-1:0]  cpu_addr;
  logic           cpu_w_notr;
  logic [WSZ-1:0] cpu_wdata;
  logic [WSZ-1:0] cpu_rdata;
  logic           cpu_wait;
  logic           cpu_rx_interrupt;
  logic           cpu_tx_interrupt;

  logic           io_rx_interrupt;
  logic [WSZ-1:0] io_rdata;
  logic           io_rx_ack;
  logic           io_tx_interrupt;
  logic [WSZ-1:0] io_wdata;
  logic           io_w_notr;
  logic [SZ-1:0]  io_addr;

  modport slave (
    input  ram_rdata, cpu_req, cpu_addr, cpu_w_notr, cpu_wdata,
           io_rx_interrupt, io_rdata, io_tx_interrupt,
    output ram_addr, ram_wdata, ram_w_notr, cpu_rdata, cpu_wait,
           cpu_rx_interrupt, cpu_tx_interrupt, io_rx_ack, io_wdata,
           io_w_notr, io_addr
  );

  modport master (
    output ram_rdata, cpu_req, cpu_addr, cpu_w_notr, cpu_wdata,
           io_rx_interrupt, io_rdata, io_tx_interrupt,
    input  ram_addr, ram_wdata, ram_w_notr, cpu_rdata, cpu_wait,
           cpu_rx_interrupt, cpu_tx_interrupt, io_rx_ack, io_wdata,
           io_w_notr, io_addr
  );
endinterface

// File: rtl/dma_subsystem.sv
// Two-channel DMA engine (RX: IO->RAM, TX: RAM->IO) with a CPU register window
// at the top 8 addresses; owns the single RAM port with priority RX > TX > CPU.
module dma_subsystem #(
  parameter int SZ  = 8,
  parameter int WSZ = 8
) (
  input  logic            clk,
  input  logic            rst,
  dma_subsystem_if.slave  bus
);

  logic [SZ-1:0] rx_base, rx_len, rx_cnt, rx_cnt_nxt;
  logic [SZ-1:0] tx_base, tx_len, tx_cnt, tx_cnt_nxt;
  logic          rx_busy, rx_done, tx_busy, tx_done;

  logic          reg_sel, reg_wr, cpu_mem;
  logic [2:0]    reg_idx;
  logic [3:0]    ctrl;
  logic          rx_ready, tx_ready, rx_beat, tx_beat, cpu_grant;

  assign reg_sel = &bus.cpu_addr[SZ-1:3];
  assign reg_idx = bus.cpu_addr[2:0];
  assign reg_wr  = bus.cpu_req & bus.cpu_w_notr & reg_sel;
  assign ctrl    = (reg_wr && reg_idx == 3'd4) ? bus.cpu_wdata[3:0] : 4'b0000;

  // Beats and CPU RAM grants are suppressed while rst is high so a reset aborts at once.
  assign cpu_mem  = bus.cpu_req & ~reg_sel & ~rst;
  assign rx_ready = ~rst & rx_busy & bus.io_rx_interrupt & (rx_cnt != rx_len);
  assign tx_ready = ~rst & tx_busy & bus.io_tx_interrupt & (tx_cnt != tx_len);

  assign rx_beat   = rx_ready;
  assign tx_beat   = tx_ready & ~rx_ready;
  assign cpu_grant = cpu_mem & ~rx_ready & ~tx_ready;

  assign rx_cnt_nxt = rx_cnt + 1'b1;
  assign tx_cnt_nxt = tx_cnt + 1'b1;

  assign bus.cpu_wait         = cpu_mem & (rx_ready | tx_ready);
  assign bus.cpu_rx_interrupt = rx_done;
  assign bus.cpu_tx_interrupt = tx_done;
  assign bus.io_wdata         = tx_beat ? bus.ram_rdata : '0;

  always_comb begin
    bus.ram_addr   = '0;
    bus.ram_wdata  = '0;
    bus.ram_w_notr = 1'b0;
    bus.io_rx_ack  = 1'b0;
    bus.io_w_notr  = 1'b0;
    bus.io_addr    = '0;
    if (rx_beat) begin
      bus.ram_addr   = rx_base + rx_cnt;
      bus.ram_wdata  = bus.io_rdata;
      bus.ram_w_notr = 1'b1;
      bus.io_rx_ack  = 1'b1;
      bus.io_addr    = rx_cnt;
    end else if (tx_beat) begin
      bus.ram_addr  = tx_base + tx_cnt;
      bus.io_w_notr = 1'b1;
      bus.io_addr   = tx_cnt;
    end else if (cpu_grant) begin
      bus.ram_addr   = bus.cpu_addr;
      bus.ram_wdata  = bus.cpu_wdata;
      bus.ram_w_notr = bus.cpu_w_notr;
    end
  end

  always_comb begin
    bus.cpu_rdata = '0;
    if (bus.cpu_req && !bus.cpu_w_notr) begin
      if (reg_sel) begin
        case (reg_idx)
          3'd0:    bus.cpu_rdata = WSZ'(rx_base);
          3'd1:    bus.cpu_rdata = WSZ'(rx_len);
          3'd2:    bus.cpu_rdata = WSZ'(tx_base);
          3'd3:    bus.cpu_rdata = WSZ'(tx_len);
          3'd5:    bus.cpu_rdata = WSZ'({tx_done, rx_done, tx_busy, rx_busy});
          default: bus.cpu_rdata = '0;
        endcase
      end else if (cpu_grant) begin
        bus.cpu_rdata = bus.ram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_base <= '0;
      rx_len  <= '0;
      rx_cnt  <= '0;
      rx_busy <= 1'b0;
      rx_done <= 1'b0;
      tx_base <= '0;
      tx_len  <= '0;
      tx_cnt  <= '0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      if (reg_wr) begin
        case (reg_idx)
          3'd0:    rx_base <= SZ'(bus.cpu_wdata);
          3'd1:    rx_len  <= SZ'(bus.cpu_wdata);
          3'd2:    tx_base <= SZ'(bus.cpu_wdata);
          3'd3:    tx_len  <= SZ'(bus.cpu_wdata);
          default: ;
        endcase
      end

      // Clear is applied first so a completion in the same cycle overrides it.
      if (ctrl[2]) rx_done <= 1'b0;
      if (rx_beat) begin
        rx_cnt <= rx_cnt_nxt;
        if (rx_cnt_nxt == rx_len) begin
          rx_busy <= 1'b0;
          rx_done <= 1'b1;
        end
      end else if (rx_busy && rx_cnt == rx_len) begin
        rx_busy <= 1'b0;
        rx_done <= 1'b1;
      end else if (ctrl[0] && !rx_busy) begin
        rx_cnt <= '0;
        if (rx_len == '0) rx_done <= 1'b1;
        else              rx_busy <= 1'b1;
      end

      if (ctrl[3]) tx_done <= 1'b0;
      if (tx_beat) begin
        tx_cnt <= tx_cnt_nxt;
        if (tx_cnt_nxt == tx_len) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end
      end else if (tx_busy && tx_cnt == tx_len) begin
        tx_busy <= 1'b0;
        tx_done <= 1'b1;
      end else if (ctrl[1] && !tx_busy) begin
        tx_cnt <= '0;
        if (tx_len == '0) tx_done <= 1'b1;
        else              tx_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dma_subsystem.sv
// Self-checking bench for dma_subsystem: register table, directed DMA sequences
// and randomized traffic compared against a transaction-level reference model.
module tb_dma_subsystem;

  bit clk = 1'b0;
  bit rst;
  always #5 clk = ~clk;

  dma_subsystem_if #(.SZ(8), .WSZ(8)) bus ();

  dma_subsystem #(.SZ(8), .WSZ(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] ram [256];
  assign bus.ram_rdata = ram[bus.ram_addr];

  int n_checks = 0;
  int n_err    = 0;

  // reference model: index 0 = RX channel, 1 = TX channel
  int m_base [2];
  int m_len  [2];
  int m_cnt  [2];
  bit m_busy [2];
  bit m_done [2];
  int mem_ref [256];

  logic [7:0] rx_q [$];
  logic [7:0] tx_data_q [$];
  logic [7:0] tx_addr_q [$];
  bit rx_en, tx_rdy;
  int n_ack;

  logic [7:0] smp_rdata, smp_raddr, smp_rwdata, smp_iowdata, smp_ioaddr;
  logic       smp_wait, smp_ramw, smp_ack, smp_iow, smp_rxirq, smp_txirq;

  typedef struct {
    bit         w;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_base[c] = 0; m_len[c] = 0; m_cnt[c] = 0; m_busy[c] = 0; m_done[c] = 0;
    end
  endtask

  // One clock cycle: drive IO, sample outputs at negedge, check against model, advance.
  task automatic step(input bit chk_en);
    int left [2];
    int ra, ta, idx, st, e_rdata;
    bit rx_go, tx_want, tx_go, regwin, cpu_mem, stall, e_ramw, is_ctrl;
    bit old_busy [2];
    bus.io_rx_interrupt = rx_en && (rx_q.size() > 0);
    bus.io_rdata        = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    bus.io_tx_interrupt = tx_rdy;
    @(negedge clk);
    smp_rdata = bus.cpu_rdata;   smp_wait  = bus.cpu_wait;
    smp_ramw  = bus.ram_w_notr;  smp_raddr = bus.ram_addr;   smp_rwdata = bus.ram_wdata;
    smp_ack   = bus.io_rx_ack;   smp_iow   = bus.io_w_notr;
    smp_iowdata = bus.io_wdata;  smp_ioaddr = bus.io_addr;
    smp_rxirq = bus.cpu_rx_interrupt; smp_txirq = bus.cpu_tx_interrupt;
    if (rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < 2; c++) left[c] = (m_len[c] - m_cnt[c]) & 255;
      regwin  = bus.cpu_addr >= 8'd248;
      idx     = bus.cpu_addr & 7;
      rx_go   = m_busy[0] && bus.io_rx_interrupt && left[0] > 0;
      tx_want = m_busy[1] && bus.io_tx_interrupt && left[1] > 0;
      tx_go   = tx_want && !rx_go;
      cpu_mem = bus.cpu_req && !regwin;
      stall   = cpu_mem && (rx_go || tx_want);
      ra = (m_base[0] + m_cnt[0]) & 255;
      ta = (m_base[1] + m_cnt[1]) & 255;
      st = int'(m_busy[0]) | (int'(m_busy[1]) << 1) | (int'(m_done[0]) << 2) | (int'(m_done[1]) << 3);
      e_rdata = 0;
      if (bus.cpu_req && !bus.cpu_w_notr) begin
        if (regwin) begin
          case (idx)
            0: e_rdata = m_base[0];
            1: e_rdata = m_len[0];
            2: e_rdata = m_base[1];
            3: e_rdata = m_len[1];
            5: e_rdata = st;
            default: e_rdata = 0;
          endcase
        end else if (!stall) begin
          e_rdata = mem_ref[bus.cpu_addr];
        end
      end
      e_ramw = rx_go || (cpu_mem && !stall && bus.cpu_w_notr);
      if (chk_en) begin
        chk("cpu_wait", smp_wait, stall);
        chk("cpu_rdata", smp_rdata, e_rdata);
        chk("ram_w_notr", smp_ramw, e_ramw);
        chk("io_rx_ack", smp_ack, rx_go);
        chk("io_w_notr", smp_iow, tx_go);
        chk("io_addr", smp_ioaddr, rx_go ? m_cnt[0] : (tx_go ? m_cnt[1] : 0));
        chk("rx_irq", smp_rxirq, m_done[0]);
        chk("tx_irq", smp_txirq, m_done[1]);
        if (tx_go) chk("io_wdata", smp_iowdata, mem_ref[ta]);
        if (rx_go) begin
          chk("rx_ram_addr", smp_raddr, ra);
          chk("rx_ram_wdata", smp_rwdata, bus.io_rdata);
        end
      end
      old_busy = m_busy;
      is_ctrl = bus.cpu_req && bus.cpu_w_notr && regwin && idx == 4;
      if (is_ctrl && bus.cpu_wdata[2]) m_done[0] = 0;
      if (is_ctrl && bus.cpu_wdata[3]) m_done[1] = 0;
      if (rx_go) begin
        mem_ref[ra] = bus.io_rdata;
        m_cnt[0] = (m_cnt[0] + 1) & 255;
        if (m_cnt[0] == m_len[0]) begin m_busy[0] = 0; m_done[0] = 1; end
      end
      if (tx_go) begin
        m_cnt[1] = (m_cnt[1] + 1) & 255;
        if (m_cnt[1] == m_len[1]) begin m_busy[1] = 0; m_done[1] = 1; end
      end
      if (cpu_mem && !stall && bus.cpu_w_notr) mem_ref[bus.cpu_addr] = bus.cpu_wdata;
      for (int c = 0; c < 2; c++) begin
        if (is_ctrl && bus.cpu_wdata[c] && !old_busy[c]) begin
          m_cnt[c] = 0;
          if (m_len[c] == 0) m_done[c] = 1;
          else m_busy[c] = 1;
        end
      end
      if (bus.cpu_req && bus.cpu_w_notr && regwin && idx < 4) begin
        if (idx[0]) m_len[idx >> 1] = bus.cpu_wdata;
        else m_base[idx >> 1] = bus.cpu_wdata;
      end
    end
    @(posedge clk);
    if (smp_ramw) ram[smp_raddr] = smp_rwdata;
    if (smp_ack) begin
      void'(rx_q.pop_front());
      n_ack++;
    end
    if (smp_iow) begin
      tx_data_q.push_back(smp_iowdata);
      tx_addr_q.push_back(smp_ioaddr);
    end
    #1;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    bus.cpu_req = 1; bus.cpu_w_notr = 1; bus.cpu_addr = a; bus.cpu_wdata = d;
    step(1);
    bus.cpu_req = 0; bus.cpu_w_notr = 0;
  endtask

  task automatic cpu_rd(input logic [7:0] a);
    bus.cpu_req = 1; bus.cpu_w_notr = 0; bus.cpu_addr = a; bus.cpu_wdata = 0;
    step(1);
    bus.cpu_req = 0;
  endtask

  task automatic run_until_acks(input int target, input int budget);
    for (int i = 0; i < budget && n_ack < target; i++) step(1);
    chk("ack_count", n_ack, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit e_ack [5];
    bit e_iow [5];
    bit e_wait [5];
    int base_ack, n_tx0;
    logic [7:0] a;

    tbl[0]  = '{1'b1, 8'hF8, 8'h10, 8'h00};
    tbl[1]  = '{1'b0, 8'hF8, 8'h00, 8'h10};
    tbl[2]  = '{1'b1, 8'hF9, 8'h03, 8'h00};
    tbl[3]  = '{1'b0, 8'hF9, 8'h00, 8'h03};
    tbl[4]  = '{1'b1, 8'hFA, 8'h20, 8'h00};
    tbl[5]  = '{1'b0, 8'hFA, 8'h00, 8'h20};
    tbl[6]  = '{1'b1, 8'hFB, 8'h02, 8'h00};
    tbl[7]  = '{1'b0, 8'hFB, 8'h00, 8'h02};
    tbl[8]  = '{1'b0, 8'hFD, 8'h00, 8'h00};
    tbl[9]  = '{1'b1, 8'hFF, 8'hAB, 8'h00};
    tbl[10] = '{1'b0, 8'hFF, 8'h00, 8'h00};
    tbl[11] = '{1'b0, 8'hFE, 8'h00, 8'h00};
    tbl[12] = '{1'b1, 8'h20, 8'h55, 8'h00};
    tbl[13] = '{1'b1, 8'h21, 8'h66, 8'h00};
    tbl[14] = '{1'b0, 8'h20, 8'h00, 8'h55};
    tbl[15] = '{1'b0, 8'h21, 8'h00, 8'h66};

    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    bus.cpu_req = 0; bus.cpu_w_notr = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    rx_en = 0; tx_rdy = 0; n_ack = 0;
    model_reset();

    // reset
    rst = 1;
    step(0);
    step(0);
    rst = 0;
    cpu_rd(8'hFD);
    chk("rst_status", smp_rdata, 8'h00);
    chk("rst_rx_irq", smp_rxirq, 1'b0);
    chk("rst_tx_irq", smp_txirq, 1'b0);
    chk("rst_cpu_wait", smp_wait, 1'b0);
    chk("rst_ram_w_notr", smp_ramw, 1'b0);

    // register window and CPU RAM access table
    for (int i = 0; i < 16; i++) begin
      bus.cpu_req = 1; bus.cpu_w_notr = tbl[i].w;
      bus.cpu_addr = tbl[i].addr; bus.cpu_wdata = tbl[i].wdata;
      step(1);
      chk("tbl_rdata", smp_rdata, tbl[i].exp_rdata);
      chk("tbl_wait", smp_wait, 1'b0);
    end
    bus.cpu_req = 0;

    // RX: 3 bytes into 0x10
    rx_q = '{8'hA1, 8'hA2, 8'hA3};
    rx_en = 1;
    cpu_wr(8'hFC, 8'h01);
    run_until_acks(3, 10);
    chk("rx_irq_at_last_beat", smp_rxirq, 1'b0);
    step(1);
    chk("rx_irq_after_last_beat", smp_rxirq, 1'b1);
    chk("rx_ram10", ram[8'h10], 8'hA1);
    chk("rx_ram11", ram[8'h11], 8'hA2);
    chk("rx_ram12", ram[8'h12], 8'hA3);
    cpu_wr(8'hFC, 8'h04);
    step(1);
    chk("rx_clr_irq", smp_rxirq, 1'b0);

    // TX: 2 bytes from 0x20
    tx_data_q.delete(); tx_addr_q.delete();
    tx_rdy = 1;
    cpu_wr(8'hFC, 8'h02);
    for (int i = 0; i < 10 && tx_data_q.size() < 2; i++) step(1);
    chk("tx_count", tx_data_q.size(), 2);
    if (tx_data_q.size() == 2) begin
      chk("tx_data0", tx_data_q[0], 8'h55);
      chk("tx_data1", tx_data_q[1], 8'h66);
      chk("tx_addr0", tx_addr_q[0], 8'h00);
      chk("tx_addr1", tx_addr_q[1], 8'h01);
    end
    step(1);
    chk("tx_irq", smp_txirq, 1'b1);
    tx_rdy = 0;
    cpu_wr(8'hFC, 8'h08);

    // contention: RX (2) and TX (2) active, CPU read of 0x21 held
    cpu_wr(8'hF8, 8'h40);
    cpu_wr(8'hF9, 8'h02);
    rx_q = '{8'hC1, 8'hC2};
    rx_en = 1; tx_rdy = 1;
    cpu_wr(8'hFC, 8'h0F);
    e_ack  = '{1, 1, 0, 0, 0};
    e_iow  = '{0, 0, 1, 1, 0};
    e_wait = '{1, 1, 1, 1, 0};
    bus.cpu_req = 1; bus.cpu_w_notr = 0; bus.cpu_addr = 8'h21;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("cont_ack", smp_ack, e_ack[i]);
      chk("cont_iow", smp_iow, e_iow[i]);
      chk("cont_wait", smp_wait, e_wait[i]);
    end
    chk("cont_rdata", smp_rdata, 8'h66);
    bus.cpu_req = 0; rx_en = 0; tx_rdy = 0;
    cpu_wr(8'hFC, 8'h0C);

    // RX address wrap
    cpu_wr(8'hF8, 8'hFE);
    cpu_wr(8'hF9, 8'h03);
    rx_q = '{8'hB0, 8'hB1, 8'hB2};
    rx_en = 1;
    base_ack = n_ack;
    cpu_wr(8'hFC, 8'h01);
    run_until_acks(base_ack + 3, 10);
    chk("wrap_ramFE", ram[8'hFE], 8'hB0);
    chk("wrap_ramFF", ram[8'hFF], 8'hB1);
    chk("wrap_ram00", ram[8'h00], 8'hB2);
    step(1);
    cpu_wr(8'hFC, 8'h04);

    // start while busy is ignored
    cpu_wr(8'hF8, 8'h60);
    cpu_wr(8'hF9, 8'h04);
    rx_q = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    base_ack = n_ack;
    cpu_wr(8'hFC, 8'h01);
    step(1);
    step(1);
    rx_en = 0;
    cpu_wr(8'hFC, 8'h01);
    rx_en = 1;
    run_until_acks(base_ack + 4, 10);
    chk("busy_start_ram60", ram[8'h60], 8'hD0);
    chk("busy_start_ram62", ram[8'h62], 8'hD2);
    chk("busy_start_ram63", ram[8'h63], 8'hD3);
    step(1);
    chk("busy_start_irq", smp_rxirq, 1'b1);
    rx_en = 0;
    cpu_wr(8'hFC, 8'h04);

    // LEN = 0: done next cycle, no transfer
    cpu_wr(8'hFB, 8'h00);
    tx_rdy = 1;
    n_tx0 = tx_data_q.size();
    cpu_wr(8'hFC, 8'h02);
    cpu_rd(8'hFD);
    chk("len0_status", smp_rdata, 8'h08);
    chk("len0_irq", smp_txirq, 1'b1);
    step(1);
    chk("len0_no_beat", tx_data_q.size(), n_tx0);
    tx_rdy = 0;
    cpu_wr(8'hFC, 8'h08);

    // reset mid-RX
    cpu_wr(8'hF8, 8'h80);
    cpu_wr(8'hF9, 8'h05);
    rx_q = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4};
    rx_en = 1;
    cpu_wr(8'hFC, 8'h01);
    step(1);
    step(1);
    rst = 1;
    step(0);
    rst = 0;
    rx_en = 0;
    rx_q.delete();
    cpu_rd(8'hFD);
    chk("rst_mid_status", smp_rdata, 8'h00);
    chk("rst_mid_rx_irq", smp_rxirq, 1'b0);
    chk("rst_mid_ram81", ram[8'h81], 8'hE1);
    chk("rst_mid_ram82", ram[8'h82], 8'h00);

    // randomized traffic against the reference model
    for (int it = 0; it < 20; it++) begin
      int rl, tl;
      rl = $urandom_range(1, 12);
      tl = $urandom_range(1, 12);
      cpu_wr(8'hF8, 8'($urandom_range(0, 255)));
      cpu_wr(8'hF9, 8'(rl));
      cpu_wr(8'hFA, 8'($urandom_range(0, 255)));
      cpu_wr(8'hFB, 8'(tl));
      rx_q.delete();
      for (int k = 0; k < rl; k++) rx_q.push_back(8'($urandom_range(0, 255)));
      cpu_wr(8'hFC, 8'h0F);
      for (int cyc = 0; cyc < 300 && (m_busy[0] || m_busy[1]); cyc++) begin
        rx_en  = ($urandom % 4) != 0;
        tx_rdy = ($urandom % 3) != 0;
        bus.cpu_req = $urandom % 2;
        if ($urandom % 8 == 0) begin
          a = 8'hFD;
          bus.cpu_w_notr = 0;
        end else begin
          a = 8'($urandom_range(0, 247));
          bus.cpu_w_notr = $urandom % 2;
        end
        bus.cpu_addr = a;
        bus.cpu_wdata = 8'($urandom_range(0, 255));
        step(1);
      end
      bus.cpu_req = 0; bus.cpu_w_notr = 0; rx_en = 0; tx_rdy = 0;
      cpu_rd(8'hFD);
      chk("rand_status", smp_rdata, 8'h0C);
      chk("rand_rx_drained", rx_q.size(), 0);
    end

    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== 8'(mem_ref[i])) bad++;
      chk("ram_final_mismatches", bad, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/dma_subsystem.md
# dma_subsystem

Single-clock DMA engine between a CPU port, an IO port and a shared single-port RAM. The CPU programs two channels through memory-mapped registers: RX moves bytes from IO into RAM, TX moves bytes from RAM to IO. Completion is signalled by per-channel CPU interrupts. The block owns the RAM port and arbitrates CPU accesses against DMA traffic.

## Interface
- SZ, 8, address width; RAM has 2^SZ words
- WSZ, 8, data word width
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ram_addr  out  SZ  RAM address
- ram_wdata  out  WSZ  RAM write data
- ram_rdata  in  WSZ  RAM read data, combinational from ram_addr
- ram_w_notr  out  1  1 = RAM writes ram_wdata at the next edge
- cpu_req  in  1  CPU access valid this cycle
- cpu_addr  in  SZ  CPU address
- cpu_w_notr  in  1  1 = CPU write
- cpu_wdata  in  WSZ  CPU write data
- cpu_rdata  out  WSZ  CPU read data, combinational
- cpu_wait  out  1  CPU access not granted; CPU holds the request and retries
- cpu_rx_interrupt  out  1  RX done, registered
- cpu_tx_interrupt  out  1  TX done, registered
- io_rx_interrupt  in  1  IO holds a byte on io_rdata (level)
- io_rdata  in  WSZ  IO byte for RX
- io_rx_ack  out  1  byte consumed this cycle
- io_tx_interrupt  in  1  IO ready to accept a byte (level)
- io_wdata  out  WSZ  TX byte
- io_w_notr  out  1  1 = io_wdata valid; IO latches it at the edge
- io_addr  out  SZ  index of the byte transferred this cycle (0 when idle)

## Operation
- Register window: cpu_addr ≥ 2^SZ−8. Index = cpu_addr[2:0]. These accesses never touch RAM and never wait.
  - 0 RX_BASE (r/w)
  - 1 RX_LEN (r/w)
  - 2 TX_BASE (r/w)
  - 3 TX_LEN (r/w)
  - 4 CTRL (write-only, self-clearing): bit0 rx_start, bit1 tx_start, bit2 rx_clr, bit3 tx_clr
  - 5 STATUS (ro): {rx_busy, tx_busy, rx_done, tx_done} at bits 0..3
  - 6–7 read 0, writes ignored
- Register fields are the low SZ bits of the written word.
- Start: sets busy and clears the channel count. A start while the channel is busy is ignored. A start with LEN=0 sets done on the next cycle and performs no transfer.
- Clear: clr clears done and deasserts the interrupt. If clr and the done-setting event land in the same cycle, done wins.
- RX beat (rx_busy & io_rx_interrupt & RAM granted):
  - ram_addr = RX_BASE+cnt (mod 2^SZ), ram_wdata = io_rdata, ram_w_notr = 1
  - io_rx_ack = 1, io_addr = cnt
  - cnt increments
- TX beat (tx_busy & io_tx_interrupt & RAM granted):
  - ram_addr = TX_BASE+cnt, ram_w_notr = 0
  - io_wdata = ram_rdata, io_w_notr = 1, io_addr = cnt
  - cnt increments
- When cnt reaches LEN: busy=0, done=1, interrupt=1.
- RAM arbitration, fixed priority RX > TX > CPU. A losing DMA beat retries next cycle. A losing CPU RAM access sees cpu_wait = 1 and no RAM effect.
- Granted CPU RAM access: ram_addr = cpu_addr, ram_w_notr = cpu_w_notr, cpu_rdata = ram_rdata.
- Idle port defaults: ram_w_notr = 0, io_w_notr = 0, io_rx_ack = 0, cpu_rdata = 0 unless a read is served.
- Address arithmetic wraps modulo 2^SZ.

## Timing
- Reset values: all registers, counts and busy/done bits 0; cpu_rx_interrupt = cpu_tx_interrupt = 0; all combinational outputs at idle defaults.
- Register writes take effect at the edge. The first beat can occur in the cycle after the start write.
- One beat per channel per cycle max. With no contention, throughput is 1 word/cycle.
- Interrupt rises in the cycle after the final beat.
- Reset mid-transfer aborts immediately. No partial-state retention.

## Test plan
- Reset: assert rst 2 cycles -> STATUS = 0, both interrupts 0, cpu_wait = 0, ram_w_notr = 0.
- RX: RX_BASE=0x10, RX_LEN=3, rx_start; IO supplies 0xA1,0xA2,0xA3 with io_rx_interrupt high -> RAM[0x10..0x12] = A1,A2,A3; io_rx_ack pulses 3 times; cpu_rx_interrupt = 1 one cycle after the third beat; rx_clr drops it.
- TX: preload RAM[0x20..0x21] = 0x55,0x66 via CPU; TX_BASE=0x20, TX_LEN=2, tx_start, io_tx_interrupt high -> io_wdata 0x55 then 0x66 with io_w_notr and io_addr 0,1; cpu_tx_interrupt rises.
- Contention: RX and TX active, IO both ready, CPU RAM read pending -> RX beats first, TX next cycle, cpu_wait high until both channels are idle or not ready.
- Edges: RX_BASE=0xFE, RX_LEN=3 -> writes 0xFE,0xFF,0x00. A start during busy is ignored. LEN=0 -> done next cycle. rst mid-RX -> STATUS = 0.
